// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared constants and FSM state encoding for the two-master data memory arbiter.
package pkg_arbitro_memoria;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int RAM_SIZE_DEF   = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } estado_t;

endpackage

// File: rtl/arbitro_memoria_dados_seletor.sv
// Combinational round-robin pick between two requesters; prio is owned by the parent FSM.
module seletor_round_robin (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic grant_idx,
  output logic grant_valid
);

  assign grant_valid = req0 | req1;
  // A lone requester wins outright; prio only breaks ties.
  assign grant_idx   = (req0 && req1) ? prio : req1;

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-master arbiter/sequencer for the single-port data memory (IDLE -> ISSUE -> RESP).
// The mem_* outputs double as the latched transaction, so they hold outside ISSUE.
module arbitro_memoria_dados
  import pkg_arbitro_memoria::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAM_SIZE   = RAM_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  erro0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  erro1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_datain,
  input  logic [DATA_WIDTH-1:0] mem_dataout,
  output logic                  ocupado
);

  localparam logic [ADDR_WIDTH-1:0] LIMITE = ADDR_WIDTH'(RAM_SIZE);

  estado_t r_state;
  logic    r_prio;
  logic    r_master;
  logic    r_fora;
  logic    r_ack0;
  logic    r_ack1;
  logic    r_erro;

  logic                  w_gnt;
  logic                  w_gnt_valid;
  logic                  w_we_sel;
  logic [ADDR_WIDTH-1:0] w_addr_sel;
  logic [DATA_WIDTH-1:0] w_wdata_sel;
  logic                  w_in_range;

  seletor_round_robin u_seletor (
    .req0        (req0),
    .req1        (req1),
    .prio        (r_prio),
    .grant_idx   (w_gnt),
    .grant_valid (w_gnt_valid)
  );

  assign w_we_sel    = w_gnt ? we1    : we0;
  assign w_addr_sel  = w_gnt ? addr1  : addr0;
  assign w_wdata_sel = w_gnt ? wdata1 : wdata0;
  assign w_in_range  = (w_addr_sel < LIMITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_master   <= 1'b0;
      r_fora     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_erro     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_erro <= 1'b0;
          if (w_gnt_valid) begin
            r_master   <= w_gnt;
            r_prio     <= ~w_gnt;
            r_fora     <= ~w_in_range;
            mem_addr   <= w_addr_sel;
            mem_datain <= w_wdata_sel;
            mem_we     <= w_we_sel & w_in_range;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we  <= 1'b0;
          r_ack0  <= ~r_master;
          r_ack1  <= r_master;
          r_erro  <= r_fora;
          r_state <= RESP;
        end
        RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_erro  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          mem_we  <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_erro  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory read data is only valid during RESP, so it is steered combinationally.
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign erro0   = r_ack0 & r_erro;
  assign erro1   = r_ack1 & r_erro;
  assign rdata0  = (r_ack0 && !r_erro) ? mem_dataout : '0;
  assign rdata1  = (r_ack1 && !r_erro) ? mem_dataout : '0;
  assign ocupado = (r_state != IDLE);

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Self-checking bench: behavioural 2048-word memory with registered read, scoreboard of expected acks.
module tb_arbitro_memoria_dados;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, erro0, ack1, erro1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_datain;
  logic [31:0] mem_dataout;
  logic        ocupado;

  logic [31:0] mem_model [0:2047];

  typedef struct {
    int          m;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  arbitro_memoria_dados dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .erro0(erro0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .erro1(erro1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr[10:0]] <= mem_datain;
    mem_dataout <= mem_model[mem_addr[10:0]];
  end

  // Drives one request from master m and waits (bounded) for its ack; checks are done by callers.
  task automatic access(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit corrupt,
                        output int cyc, output logic [31:0] rd, output logic er,
                        output int n_we, output logic [31:0] we_addr,
                        output bit other_ack, output bit timeout);
    @(negedge clk);
    if (m == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else        begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    cyc = 0; n_we = 0; we_addr = 0; other_ack = 0; timeout = 1; rd = 0; er = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      cyc = i;
      if (corrupt && i == 1) begin
        if (m == 0) begin addr0 = ~addr; wdata0 = ~wd; end
        else        begin addr1 = ~addr; wdata1 = ~wd; end
      end
      if (mem_we) begin n_we++; we_addr = mem_addr; end
      if ((m == 0) ? ack1 : ack0) other_ack = 1;
      if ((m == 0) ? ack0 : ack1) begin
        rd = (m == 0) ? rdata0 : rdata1;
        er = (m == 0) ? erro0 : erro1;
        timeout = 0;
        break;
      end
    end
    if (m == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack0, ack1, erro0, erro1, mem_we, ocupado} !== 6'b0 || mem_addr !== 0 || mem_datain !== 0
        || rdata0 !== 0 || rdata1 !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack0=%b ack1=%b mem_we=%b ocupado=%b mem_addr=%h expected all zero",
               ack0, ack1, mem_we, ocupado, mem_addr);
    end
    reset = 0;
    @(negedge clk);
    n_checks++;
    if (ocupado !== 1'b0 || ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ocupado=%b ack0=%b expected 0 0", ocupado, ack0);
    end
  endtask

  task automatic test_write();
    int cyc, nwe; logic [31:0] rd, wa; logic er; bit oth, to; exp_t ex;
    sb.push_back('{0, 32'h0, 1'b0});
    access(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1, cyc, rd, er, nwe, wa, oth, to);
    ex = sb.pop_front();
    n_checks++;
    if (to || cyc != 2) begin
      n_fail++; $display("FAIL write_latency: cycles=%0d timeout=%0b expected 2", cyc, to);
    end
    n_checks++;
    if (nwe != 1 || wa !== 32'd5) begin
      n_fail++; $display("FAIL write_mem_we: pulses=%0d addr=%0d expected 1 at 5", nwe, wa);
    end
    n_checks++;
    if (er !== ex.e || rd !== ex.d || oth) begin
      n_fail++; $display("FAIL write_ack: erro0=%b rdata0=%h ack1_seen=%0b expected %b %h 0", er, rd, oth, ex.e, ex.d);
    end
    n_checks++;
    if (mem_model[5] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_mem_content: mem[5]=%h expected deadbeef", mem_model[5]);
    end
  endtask

  task automatic test_read();
    int cyc, nwe; logic [31:0] rd, wa; logic er; bit oth, to; exp_t ex;
    sb.push_back('{1, 32'hDEADBEEF, 1'b0});
    access(1, 1'b0, 32'd5, 32'h0, 1'b0, cyc, rd, er, nwe, wa, oth, to);
    ex = sb.pop_front();
    n_checks++;
    if (to || cyc != 2 || oth) begin
      n_fail++; $display("FAIL read_latency: cycles=%0d timeout=%0b ack0_seen=%0b expected 2", cyc, to, oth);
    end
    n_checks++;
    if (rd !== ex.d || er !== ex.e || nwe != 0) begin
      n_fail++; $display("FAIL read_data: rdata1=%h erro1=%b mem_we_pulses=%0d expected %h %b 0", rd, er, nwe, ex.d, ex.e);
    end
  endtask

  task automatic test_out_of_range();
    int cyc, nwe; logic [31:0] rd, wa; logic er; bit oth, to; exp_t ex;
    sb.push_back('{0, 32'h0, 1'b1});
    access(0, 1'b1, 32'd2048, 32'hAAAA5555, 1'b0, cyc, rd, er, nwe, wa, oth, to);
    ex = sb.pop_front();
    n_checks++;
    if (to || nwe != 0 || er !== ex.e || rd !== ex.d) begin
      n_fail++; $display("FAIL oor_write: timeout=%0b mem_we_pulses=%0d erro0=%b rdata0=%h expected 0 0 1 0", to, nwe, er, rd);
    end
    n_checks++;
    if (mem_model[0] !== 32'h0) begin
      n_fail++; $display("FAIL oor_alias: mem[0]=%h expected 0", mem_model[0]);
    end
    sb.push_back('{0, 32'h0, 1'b0});
    access(0, 1'b1, 32'd2047, 32'h0BADF00D, 1'b0, cyc, rd, er, nwe, wa, oth, to);
    ex = sb.pop_front();
    n_checks++;
    if (to || nwe != 1 || wa !== 32'd2047 || er !== ex.e) begin
      n_fail++; $display("FAIL last_word_write: mem_we_pulses=%0d addr=%0d erro0=%b expected 1 2047 0", nwe, wa, er);
    end
    sb.push_back('{0, 32'h0BADF00D, 1'b0});
    access(0, 1'b0, 32'd2047, 32'h0, 1'b0, cyc, rd, er, nwe, wa, oth, to);
    ex = sb.pop_front();
    n_checks++;
    if (to || er !== ex.e || rd !== ex.d) begin
      n_fail++; $display("FAIL last_word_read: erro0=%b rdata0=%h expected %b %h", er, rd, ex.e, ex.d);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, last, acks; exp_t ex;
    do_reset();
    mem_model[10] = 32'h0000_1010;
    mem_model[11] = 32'h0000_1111;
    for (int k = 0; k < 6; k++)
      sb.push_back('{k % 2, (k % 2 == 0) ? 32'h0000_1010 : 32'h0000_1111, 1'b0});
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'd10;
    req1 = 1; we1 = 0; addr1 = 32'd11;
    cyc = 0; last = -1; acks = 0;
    while (cyc < 30 && acks < 6) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        ex = sb.pop_front();
        n_checks++;
        if ((ack0 && ack1) || (ex.m == 0 ? !ack0 : !ack1)) begin
          n_fail++; $display("FAIL rr_grant[%0d]: ack0=%b ack1=%b expected master %0d", acks, ack0, ack1, ex.m);
        end
        n_checks++;
        if ((ex.m == 0 ? rdata0 : rdata1) !== ex.d) begin
          n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", acks, (ex.m == 0 ? rdata0 : rdata1), ex.d);
        end
        n_checks++;
        if (cyc - last != ((last < 0) ? 3 : 3) && !(last < 0 && cyc == 2)) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: ack at cycle %0d previous %0d expected spacing 3", acks, cyc, last);
        end
        last = cyc;
        acks++;
      end
    end
    req0 = 0; req1 = 0;
    n_checks++;
    if (acks != 6) begin
      n_fail++; $display("FAIL rr_count: acks=%0d expected 6", acks);
    end
    while (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; bit got; exp_t ex;
    mem_model[7] = 32'h7070_7070;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'd7; wdata0 = 32'h7777_7777;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || ocupado !== 1'b1) begin
      n_fail++; $display("FAIL mid_issue: mem_we=%b ocupado=%b expected 1 1", mem_we, ocupado);
    end
    #1 reset = 1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || ocupado !== 1'b0 || mem_addr !== 0 || mem_datain !== 0) begin
      n_fail++; $display("FAIL async_clear: mem_we=%b ocupado=%b mem_addr=%h mem_datain=%h expected zeros",
                         mem_we, ocupado, mem_addr, mem_datain);
    end
    req0 = 0;
    got = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack0 || ack1) got = 1;
    end
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1) got = 1;
    end
    n_checks++;
    if (got || mem_model[7] !== 32'h7070_7070) begin
      n_fail++; $display("FAIL aborted_write: ack_seen=%0b mem[7]=%h expected 0 70707070", got, mem_model[7]);
    end
    sb.push_back('{0, 32'h7070_7070, 1'b0});
    req0 = 1; we0 = 0; addr0 = 32'd7;
    req1 = 1; we1 = 0; addr1 = 32'd11;
    got = 0; cyc = 0;
    while (cyc < 10 && !got) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) got = 1;
    end
    ex = sb.pop_front();
    n_checks++;
    if (!got || !ack0 || ack1 || rdata0 !== ex.d) begin
      n_fail++; $display("FAIL prio_after_reset: got=%0b ack0=%b ack1=%b rdata0=%h expected 1 1 0 %h",
                         got, ack0, ack1, rdata0, ex.d);
    end
    req0 = 0; req1 = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
